// File: rtl/mul_acc_stage.sv
// Multiply-accumulate back half: sums a programmed number of 128-bit products into a
// guarded accumulator and offers the result on a valid/ready handshake.
// Optional build macro MUL_ACC_SATURATE_EN clamps the accumulator on overflow instead of wrapping.
module mul_acc_stage #(
  parameter int GUARD = 8,
  parameter int CNT_W = 8,
  localparam int ACC_W = 128 + GUARD
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [CNT_W-1:0] len,
  input  logic [127:0]     prod,
  input  logic             prod_valid,
  output logic             prod_ready,
  output logic [ACC_W-1:0] acc_out,
  output logic             acc_valid,
  input  logic             acc_ready,
  output logic             busy,
  output logic             ovf
);

  typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

  state_t             state;
  state_t             state_next;
  logic [ACC_W-1:0]   acc;
  logic [CNT_W-1:0]   remaining;
  logic               ovf_flag;
  logic signed [ACC_W:0] sum_ext;
  logic               take;

  // Unsigned add with the carry kept in the extra top bit.
  function automatic logic [ACC_W:0] add_ext(input logic [ACC_W-1:0] a,
                                             input logic [127:0] p);
    logic [ACC_W:0] p_ext;
    p_ext        = '0;
    p_ext[127:0] = p;
    return {1'b0, a} + p_ext;
  endfunction

  function automatic logic [ACC_W-1:0] settle(input logic [ACC_W:0] s);
`ifdef MUL_ACC_SATURATE_EN
    return s[ACC_W] ? {ACC_W{1'b1}} : s[ACC_W-1:0];
`else
    return s[ACC_W-1:0];
`endif
  endfunction

  assign take       = (state == ACCUM) && prod_valid;
  assign sum_ext    = signed'(add_ext(acc, prod));
  assign prod_ready = (state == ACCUM);
  assign acc_valid  = (state == DONE);
  assign busy       = (state != IDLE);
  assign acc_out    = acc;
  assign ovf        = ovf_flag;

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (start) state_next = (len == '0) ? DONE : ACCUM;
      end
      ACCUM: begin
        if (take && remaining == CNT_W'(1)) state_next = DONE;
      end
      DONE: begin
        if (acc_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      acc       <= '0;
      remaining <= '0;
      ovf_flag  <= 1'b0;
    end else begin
      state <= state_next;
      if (state == IDLE && start) begin
        acc       <= '0;
        ovf_flag  <= 1'b0;
        remaining <= len;
      end else if (take) begin
        acc       <= settle(sum_ext);
        ovf_flag  <= ovf_flag | sum_ext[ACC_W];
        remaining <= remaining - CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_mul_acc_stage.sv
// Scoreboard bench for mul_acc_stage: directed vectors push expected sums, monitors pop
// and compare on each accepted result; a second GUARD=0 instance covers overflow.
module tb_mul_acc_stage;

  typedef struct {
    logic [135:0] acc;
    logic         ovf;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [7:0]   len = '0;
  logic [127:0] prod = '0;
  logic         prod_valid = 1'b0;
  logic         prod_ready;
  logic [135:0] acc_out;
  logic         acc_valid;
  logic         acc_ready = 1'b1;
  logic         busy;
  logic         ovf;

  logic         start2 = 1'b0;
  logic [7:0]   len2 = '0;
  logic [127:0] prod2 = '0;
  logic         prod_valid2 = 1'b0;
  logic         prod_ready2;
  logic [127:0] acc_out2;
  logic         acc_valid2;
  logic         acc_ready2 = 1'b1;
  logic         busy2;
  logic         ovf2;

  int total = 0;
  int bad = 0;
  exp_t q[$];
  exp_t q2[$];
  logic [127:0] ones = '1;
  logic [135:0] held;

  mul_acc_stage #(.GUARD(8), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .len(len), .prod(prod),
    .prod_valid(prod_valid), .prod_ready(prod_ready), .acc_out(acc_out),
    .acc_valid(acc_valid), .acc_ready(acc_ready), .busy(busy), .ovf(ovf)
  );

  mul_acc_stage #(.GUARD(0), .CNT_W(8)) dut_g0 (
    .clk(clk), .rst_n(rst_n), .start(start2), .len(len2), .prod(prod2),
    .prod_valid(prod_valid2), .prod_ready(prod_ready2), .acc_out(acc_out2),
    .acc_valid(acc_valid2), .acc_ready(acc_ready2), .busy(busy2), .ovf(ovf2)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [135:0] act, input logic [135:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [7:0] l);
    start = 1'b1;
    len   = l;
    tick();
    start = 1'b0;
  endtask

  // Result monitors: a handshake seen at the falling edge completes on the next rising edge.
  always @(negedge clk) begin
    if (rst_n && acc_valid && acc_ready) begin
      if (q.size() == 0) begin
        check("unexpected_result", acc_out, 136'h0 - 136'h1);
      end else begin
        exp_t e;
        e = q.pop_front();
        check("acc_out", acc_out, e.acc);
        check("ovf", {135'h0, ovf}, {135'h0, e.ovf});
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && acc_valid2 && acc_ready2) begin
      if (q2.size() == 0) begin
        check("unexpected_result_g0", {8'h0, acc_out2}, 136'h0 - 136'h1);
      end else begin
        exp_t e;
        e = q2.pop_front();
        check("acc_out_g0", {8'h0, acc_out2}, e.acc);
        check("ovf_g0", {135'h0, ovf2}, {135'h0, e.ovf});
      end
    end
  end

  initial begin
    // Reset state.
    tick();
    tick();
    check("rst_acc_out", acc_out, 136'h0);
    check("rst_ctrl", {132'h0, acc_valid, prod_ready, busy, ovf}, 136'h0);
    rst_n = 1'b1;
    tick();

    // Basic: 5 + 7 + 11.
    q.push_back('{acc: 136'd23, ovf: 1'b0});
    do_start(8'd3);
    check("basic_prod_ready", {135'h0, prod_ready}, 136'h1);
    prod_valid = 1'b1;
    prod = 128'd5;  tick();
    prod = 128'd7;  tick();
    check("basic_valid_early", {135'h0, acc_valid}, 136'h0);
    prod = 128'd11; tick();
    prod_valid = 1'b0;
    check("basic_valid", {135'h0, acc_valid}, 136'h1);
    tick();
    check("basic_idle", {134'h0, acc_valid, busy}, 136'h0);

    // Reset mid-accumulation abandons it.
    do_start(8'd4);
    prod_valid = 1'b1;
    prod = 128'd1; tick();
    prod = 128'd2; tick();
    prod_valid = 1'b0;
    rst_n = 1'b0;
    tick();
    tick();
    check("midrst_acc_out", acc_out, 136'h0);
    check("midrst_ctrl", {132'h0, acc_valid, prod_ready, busy, ovf}, 136'h0);
    rst_n = 1'b1;
    tick();
    check("midrst_after", {134'h0, acc_valid, busy}, 136'h0);
    q.push_back('{acc: 136'd9, ovf: 1'b0});
    do_start(8'd1);
    prod_valid = 1'b1;
    prod = 128'd9; tick();
    prod_valid = 1'b0;
    check("midrst_new_valid", {135'h0, acc_valid}, 136'h1);
    tick();

    // Stalled input, then held-off output.
    q.push_back('{acc: 136'h1 << 128, ovf: 1'b0});
    do_start(8'd2);
    acc_ready = 1'b0;
    repeat (3) tick();
    prod_valid = 1'b1; prod = ones; tick();
    prod_valid = 1'b0;
    repeat (3) tick();
    prod_valid = 1'b1; prod = 128'd1; tick();
    prod_valid = 1'b0;
    held = acc_out;
    check("stall_sum", held, 136'h1 << 128);
    for (int i = 0; i < 5; i++) begin
      check("stall_valid_hold", {135'h0, acc_valid}, 136'h1);
      check("stall_out_hold", acc_out, held);
      tick();
    end
    acc_ready = 1'b1;
    tick();
    check("stall_released", {135'h0, acc_valid}, 136'h0);
    check("stall_out_retained", acc_out, held);

    // len=0, with start coinciding with acc_ready in DONE.
    q.push_back('{acc: 136'h0, ovf: 1'b0});
    do_start(8'd0);
    check("len0_valid", {135'h0, acc_valid}, 136'h1);
    check("len0_prod_ready", {135'h0, prod_ready}, 136'h0);
    start = 1'b1;
    len = 8'd1;
    tick();
    start = 1'b0;
    check("done_start_ignored", {134'h0, busy, prod_ready}, 136'h0);

    // start during ACCUM does not reload the count.
    q.push_back('{acc: 136'd7, ovf: 1'b0});
    do_start(8'd2);
    start = 1'b1; len = 8'd5;
    prod_valid = 1'b1; prod = 128'd3; tick();
    start = 1'b0;
    prod = 128'd4; tick();
    prod_valid = 1'b0;
    check("accum_start_ignored", {135'h0, acc_valid}, 136'h1);
    tick();

    // prod_valid in IDLE is not consumed.
    prod_valid = 1'b1; prod = 128'd100;
    tick();
    tick();
    check("idle_prod_ready", {134'h0, prod_ready, busy}, 136'h0);
    check("idle_acc_kept", acc_out, 136'd7);
    prod_valid = 1'b0;

    // Overflow on the GUARD=0 instance.
`ifdef MUL_ACC_SATURATE_EN
    q2.push_back('{acc: {8'h0, ones}, ovf: 1'b1});
`else
    q2.push_back('{acc: {8'h0, ones - 128'd1}, ovf: 1'b1});
`endif
    start2 = 1'b1; len2 = 8'd2;
    tick();
    start2 = 1'b0;
    prod_valid2 = 1'b1; prod2 = ones; tick();
    check("g0_no_ovf_yet", {135'h0, ovf2}, 136'h0);
    tick();
    prod_valid2 = 1'b0;
    check("g0_valid", {135'h0, acc_valid2}, 136'h1);
    tick();

    for (int i = 0; i < 20 && (q.size() != 0 || q2.size() != 0); i++) tick();
    if (q.size() != 0 || q2.size() != 0) begin
      total++;
      bad++;
      $display("FAIL drain pending=%0d required=0", q.size() + q2.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
